// File: rtl/seq_signed_bcd_display.sv
// Multi-cycle signed/unsigned binary to seven-segment decimal display (double-dabble engine).
// Optional build macro SEQ_BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seq_signed_bcd_display #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    val,
  input  logic                is_signed,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [6:0]          seg7_neg_sign,
  output logic [7*DIGITS-1:0] seg7_digits
);

  localparam int unsigned BCD_W = 4*DIGITS + 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;
  localparam logic [6:0]  SEG_ZERO  = 7'h40;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_last;

  logic [WIDTH-1:0]     r_val;
  logic                 r_signed;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mag;
  logic [BCD_W-1:0]     r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sticky;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [6:0]           r_seg_sign;
  logic [7*DIGITS-1:0]  r_seg_digits;

  logic                 w_neg;
  logic [WIDTH-1:0]     w_mag_load;
  logic [BCD_W-1:0]     w_bcd_adj;
  logic [BCD_W-1:0]     w_bcd_shl;
  logic [WIDTH-1:0]     w_mag_shl;
  logic                 w_sticky_nxt;
  logic                 w_ovf;
  logic [7*DIGITS-1:0]  w_seg_digits;

  function automatic logic [6:0] seg7_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7_of = 7'h40;
      4'd1:    seg7_of = 7'h79;
      4'd2:    seg7_of = 7'h24;
      4'd3:    seg7_of = 7'h30;
      4'd4:    seg7_of = 7'h19;
      4'd5:    seg7_of = 7'h12;
      4'd6:    seg7_of = 7'h02;
      4'd7:    seg7_of = 7'h78;
      4'd8:    seg7_of = 7'h00;
      4'd9:    seg7_of = 7'h10;
      default: seg7_of = SEG_BLANK;
    endcase
  endfunction

  // Sequencing: IDLE -> LOAD -> SHIFT (WIDTH cycles) -> DONE -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_neg      = r_signed & r_val[WIDTH-1];
  assign w_mag_load = w_neg ? WIDTH'(~r_val + WIDTH'(1)) : r_val;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, mag} left
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i <= DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bcd_shl    = {w_bcd_adj[BCD_W-2:0], r_mag[WIDTH-1]};
  assign w_mag_shl    = {r_mag[WIDTH-2:0], 1'b0};
  assign w_sticky_nxt = r_sticky | w_bcd_adj[BCD_W-1];
  assign w_ovf        = w_sticky_nxt | (w_bcd_shl[BCD_W-1 -: 4] != 4'd0);

  // Display patterns built from the final shift result, loaded on entry to DONE
  always_comb begin
    logic [3:0] w_nib;
    logic [6:0] w_seg;
`ifdef SEQ_BCD_LEADING_ZERO_BLANK_EN
    logic       w_lead;
    w_lead = 1'b1;
`endif
    w_nib        = 4'd0;
    w_seg        = SEG_BLANK;
    w_seg_digits = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      w_nib = w_bcd_shl[4*i +: 4];
      w_seg = seg7_of(w_nib);
`ifdef SEQ_BCD_LEADING_ZERO_BLANK_EN
      if (w_lead && (i != 0) && (w_nib == 4'd0)) w_seg = SEG_BLANK;
      if (w_nib != 4'd0) w_lead = 1'b0;
`endif
      if (w_ovf) w_seg = SEG_DASH;
      w_seg_digits[7*i +: 7] = w_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val        <= '0;
      r_signed     <= 1'b0;
      r_neg        <= 1'b0;
      r_mag        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_sticky     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_seg_sign   <= SEG_BLANK;
      r_seg_digits <= {DIGITS{SEG_ZERO}};
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_last;
      if (w_accept) begin
        r_val    <= val;
        r_signed <= is_signed;
      end
      if (w_load) begin
        r_neg    <= w_neg;
        r_mag    <= w_mag_load;
        r_bcd    <= '0;
        r_cnt    <= CNT_W'(WIDTH);
        r_sticky <= 1'b0;
      end
      if (w_shift) begin
        r_bcd    <= w_bcd_shl;
        r_mag    <= w_mag_shl;
        r_cnt    <= r_cnt - CNT_W'(1);
        r_sticky <= w_sticky_nxt;
      end
      if (w_last) begin
        r_overflow   <= w_ovf;
        r_seg_digits <= w_seg_digits;
        r_seg_sign   <= r_neg ? SEG_DASH : SEG_BLANK;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign overflow      = r_overflow;
  assign seg7_neg_sign = r_seg_sign;
  assign seg7_digits   = r_seg_digits;

endmodule

// File: tb/tb_seq_signed_bcd_display.sv
// Bench for seq_signed_bcd_display: 8-bit and 16-bit instances (3 digits) against an arithmetic model.
module tb_seq_signed_bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  val8 = '0;
  logic        start16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] val16 = '0;

  logic        busy8, done8, ovf8, busy16, done16, ovf16;
  logic [6:0]  sign8, sign16;
  logic [20:0] dig8, dig16;

  seq_signed_bcd_display #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .val(val8), .is_signed(sgn8),
    .busy(busy8), .done(done8), .overflow(ovf8),
    .seg7_neg_sign(sign8), .seg7_digits(dig8)
  );

  seq_signed_bcd_display #(.WIDTH(16), .DIGITS(3)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .val(val16), .is_signed(sgn16),
    .busy(busy16), .done(done16), .overflow(ovf16),
    .seg7_neg_sign(sign16), .seg7_digits(dig16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        sel16 = 1'b0;
  logic        m_busy, m_done, m_ovf;
  logic [6:0]  m_sign;
  logic [20:0] m_dig;
  assign m_busy = sel16 ? busy16 : busy8;
  assign m_done = sel16 ? done16 : done8;
  assign m_ovf  = sel16 ? ovf16  : ovf8;
  assign m_sign = sel16 ? sign16 : sign8;
  assign m_dig  = sel16 ? dig16  : dig8;

  // Results of the last conversion driven by convert()
  int          res_lat, res_busy_cnt;
  logic        res_early;
  logic [1:0]  res_post;
  logic [20:0] res_dig;
  logic [6:0]  res_sign;
  logic        res_ovf;

  localparam logic [20:0] RST_DIG = {3{7'h40}};

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  // Reference: plain integer arithmetic on the value's decimal representation
  function automatic void model(input int width, input logic [15:0] v, input bit s,
                                output logic [20:0] e_dig, output logic [6:0] e_sign,
                                output logic e_ovf);
    longint raw, mag, p;
    bit neg;
    raw    = longint'(v) & ((longint'(1) << width) - 1);
    neg    = s && (((raw >> (width - 1)) & 1) == 1);
    mag    = neg ? (longint'(1) << width) - raw : raw;
    e_ovf  = (mag >= 1000);
    e_sign = neg ? 7'h3F : 7'h7F;
    p      = 1;
    e_dig  = '0;
    for (int i = 0; i < 3; i++) begin
      e_dig[7*i +: 7] = seg_ref(int'((mag / p) % 10));
`ifdef SEQ_BCD_LEADING_ZERO_BLANK_EN
      if (i > 0 && mag < p) e_dig[7*i +: 7] = 7'h7F;
`endif
      if (e_ovf) e_dig[7*i +: 7] = 7'h3F;
      p = p * 10;
    end
  endfunction

  // Drive one start pulse and follow the handshake (bounded wait; res_lat = -1 on timeout)
  task automatic convert(input bit use16, input logic [15:0] v, input bit s);
    logic [20:0] d0;
    logic [6:0]  s0;
    logic        o0;
    sel16 = use16;
    @(posedge clk); #1;
    if (use16) begin val16 = v; sgn16 = s; start16 = 1'b1; end
    else begin val8 = v[7:0]; sgn8 = s; start8 = 1'b1; end
    d0 = m_dig; s0 = m_sign; o0 = m_ovf;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    val8 = 8'($urandom); val16 = 16'($urandom); sgn8 = ~sgn8; sgn16 = ~sgn16;
    res_lat = -1; res_busy_cnt = 0; res_early = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (m_busy) res_busy_cnt++;
      if (m_done) begin res_lat = j + 1; break; end
      if (m_dig !== d0 || m_sign !== s0 || m_ovf !== o0) res_early = 1'b1;
      @(posedge clk); #1;
    end
    res_dig = m_dig; res_sign = m_sign; res_ovf = m_ovf;
    @(posedge clk); #1;
    res_post = {m_busy, m_done};
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, ovf8, sign8, dig8} !== {3'b000, 7'h7F, RST_DIG}) begin
      n_fail++;
      $display("FAIL reset_dut8: got %h expected %h", {busy8, done8, ovf8, sign8, dig8}, {3'b000, 7'h7F, RST_DIG});
    end
    n_checks++;
    if ({busy16, done16, ovf16, sign16, dig16} !== {3'b000, 7'h7F, RST_DIG}) begin
      n_fail++;
      $display("FAIL reset_dut16: got %h expected %h", {busy16, done16, ovf16, sign16, dig16}, {3'b000, 7'h7F, RST_DIG});
    end
    start8 = 1'b0; start16 = 1'b0; rst = 1'b0;
  endtask

  task automatic test_directed8();
    logic [7:0] vv [8] = '{8'hF6, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h05, 8'hFF};
    bit         ss [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [20:0] e_dig; logic [6:0] e_sign; logic e_ovf;
    for (int k = 0; k < 8; k++) begin
      convert(1'b0, {8'h00, vv[k]}, ss[k]);
      model(8, {8'h00, vv[k]}, ss[k], e_dig, e_sign, e_ovf);
      n_checks++;
      if (res_lat !== 10 || res_busy_cnt !== 10 || res_post !== 2'b00 || res_early !== 1'b0) begin
        n_fail++;
        $display("FAIL timing8 val=%h: lat=%0d busy_cycles=%0d post=%b early=%b expected lat=10 busy=10 post=00 early=0",
                 vv[k], res_lat, res_busy_cnt, res_post, res_early);
      end
      n_checks++;
      if ({res_ovf, res_sign, res_dig} !== {e_ovf, e_sign, e_dig}) begin
        n_fail++;
        $display("FAIL display8 val=%h signed=%0d: got %h expected %h", vv[k], ss[k],
                 {res_ovf, res_sign, res_dig}, {e_ovf, e_sign, e_dig});
      end
    end
  endtask

  task automatic test_overflow16();
    logic [15:0] vv [7] = '{16'd1000, 16'd999, 16'hFFFF, 16'h8000, 16'hFC18, 16'hFC19, 16'hFFFF};
    bit          ss [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [20:0] e_dig; logic [6:0] e_sign; logic e_ovf;
    for (int k = 0; k < 7; k++) begin
      convert(1'b1, vv[k], ss[k]);
      model(16, vv[k], ss[k], e_dig, e_sign, e_ovf);
      n_checks++;
      if (res_lat !== 18 || res_busy_cnt !== 18 || res_post !== 2'b00 || res_early !== 1'b0) begin
        n_fail++;
        $display("FAIL timing16 val=%h: lat=%0d busy_cycles=%0d post=%b early=%b expected lat=18 busy=18 post=00 early=0",
                 vv[k], res_lat, res_busy_cnt, res_post, res_early);
      end
      n_checks++;
      if ({res_ovf, res_sign, res_dig} !== {e_ovf, e_sign, e_dig}) begin
        n_fail++;
        $display("FAIL overflow16 val=%h signed=%0d: got %h expected %h", vv[k], ss[k],
                 {res_ovf, res_sign, res_dig}, {e_ovf, e_sign, e_dig});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v; bit s; bit w16;
    logic [20:0] e_dig; logic [6:0] e_sign; logic e_ovf;
    for (int k = 0; k < 45; k++) begin
      w16 = (k >= 30);
      v   = w16 ? 16'($urandom) : {8'h00, 8'($urandom)};
      if (w16 && (k % 3 == 0)) v = 16'($urandom_range(0, 1100));
      s   = 1'($urandom);
      convert(w16, v, s);
      model(w16 ? 16 : 8, v, s, e_dig, e_sign, e_ovf);
      n_checks++;
      if ({res_ovf, res_sign, res_dig} !== {e_ovf, e_sign, e_dig} || res_lat !== (w16 ? 18 : 10)) begin
        n_fail++;
        $display("FAIL random w16=%0d val=%h signed=%0d: got %h lat=%0d expected %h lat=%0d", w16, v, s,
                 {res_ovf, res_sign, res_dig}, res_lat, {e_ovf, e_sign, e_dig}, w16 ? 18 : 10);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [20:0] e_dig; logic [6:0] e_sign; logic e_ovf;
    int t_done, n_extra;
    sel16 = 1'b0;
    @(posedge clk); #1;
    val8 = 8'd42; sgn8 = 1'b0; start8 = 1'b1;             // cycle 0
    @(posedge clk); #1; start8 = 1'b0;                     // cycle 1
    @(posedge clk); #1;                                    // cycle 2
    @(posedge clk); #1;                                    // cycle 3
    @(posedge clk); #1; val8 = 8'd7; start8 = 1'b1;        // cycle 4
    @(posedge clk); #1; start8 = 1'b0;                     // cycle 5
    t_done = -1;
    for (int t = 5; t < 30; t++) begin
      if (done8) begin t_done = t; break; end
      @(posedge clk); #1;
    end
    model(8, 16'd42, 1'b0, e_dig, e_sign, e_ovf);
    n_checks++;
    if (t_done !== 10 || {ovf8, sign8, dig8} !== {e_ovf, e_sign, e_dig}) begin
      n_fail++;
      $display("FAIL ignore_start: done_cycle=%0d display=%h expected done_cycle=10 display=%h",
               t_done, {ovf8, sign8, dig8}, {e_ovf, e_sign, e_dig});
    end
    n_extra = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      if (done8 || busy8) n_extra++;
    end
    n_checks++;
    if (n_extra !== 0) begin
      n_fail++;
      $display("FAIL ignore_start_queued: got %0d busy/done cycles expected 0", n_extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e_dig; logic [6:0] e_sign; logic e_ovf;
    int n_done;
    convert(1'b0, 16'h0080, 1'b1);
    n_checks++;
    if (res_sign !== 7'h3F) begin
      n_fail++;
      $display("FAIL reset_mid_setup: sign got %h expected 3f", res_sign);
    end
    @(posedge clk); #1; val8 = 8'd99; sgn8 = 1'b0; start8 = 1'b1;  // cycle 3
    @(posedge clk); #1; start8 = 1'b0;                              // cycle 4
    @(posedge clk); #1; rst = 1'b1;                                 // cycle 5
    @(posedge clk); #1; rst = 1'b0;                                 // cycle 6
    n_checks++;
    if ({busy8, done8, ovf8, sign8, dig8} !== {3'b000, 7'h7F, RST_DIG}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h expected %h", {busy8, done8, ovf8, sign8, dig8}, {3'b000, 7'h7F, RST_DIG});
    end
    n_done = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      if (done8 || busy8) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d busy/done cycles expected 0", n_done);
    end
    convert(1'b0, 16'h00C8, 1'b1);
    model(8, 16'h00C8, 1'b1, e_dig, e_sign, e_ovf);
    n_checks++;
    if ({res_ovf, res_sign, res_dig} !== {e_ovf, e_sign, e_dig} || res_lat !== 10) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got %h lat=%0d expected %h lat=10",
               {res_ovf, res_sign, res_dig}, res_lat, {e_ovf, e_sign, e_dig});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vv [3] = '{8'hF6, 8'h2A, 8'h80};
    bit         ss [3] = '{1'b1, 1'b0, 1'b1};
    logic [20:0] e_dig; logic [6:0] e_sign; logic e_ovf;
    int t, k, last;
    sel16 = 1'b0;
    @(posedge clk); #1;
    val8 = vv[0]; sgn8 = ss[0]; start8 = 1'b1;
    t = 0; k = 0; last = 0;
    while (k < 3 && t < 80) begin
      @(posedge clk); #1;
      t++;
      if (done8) begin
        model(8, {8'h00, vv[k]}, ss[k], e_dig, e_sign, e_ovf);
        n_checks++;
        if ({ovf8, sign8, dig8} !== {e_ovf, e_sign, e_dig} || (t - last) !== (k == 0 ? 10 : 11)) begin
          n_fail++;
          $display("FAIL back_to_back #%0d: got %h after %0d cycles expected %h after %0d cycles", k,
                   {ovf8, sign8, dig8}, t - last, {e_ovf, e_sign, e_dig}, k == 0 ? 10 : 11);
        end
        last = t;
        k++;
        if (k < 3) begin val8 = vv[k]; sgn8 = ss[k]; end
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d done pulses expected 3", k);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_directed8();
    test_overflow16();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_signed_bcd_display.md
Name: seq_signed_bcd_display

Overview:
- Parametrised, sequential successor to the team's combinational 3-digit signed display decoder.
- Converts a WIDTH-bit value to DIGITS decimal digits using an iterative shift-add-3 (double-dabble) engine. The value is treated as signed or unsigned, selectable per conversion.
- Drives registered seven-segment patterns plus a sign segment, with a start/busy/done handshake.
- Sits between score/counter logic and the board HEX displays, replacing the wide `/` and `%` combinational logic with a small multi-cycle datapath.

Parameters:
- WIDTH, 8, input value width in bits (≥2).
- DIGITS, 3, number of decimal digits displayed (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of val; sampled only in IDLE.
- val  in  WIDTH  value to convert; captured on the accepted start.
- is_signed  in  1  1 = val is two's complement; captured with val.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the display outputs update.
- overflow  out  1  registered; magnitude ≥ 10^DIGITS.
- seg7_neg_sign  out  7  sign segment pattern.
- seg7_digits  out  7*DIGITS  digit patterns; [6:0] = ones, [13:7] = tens, and so on.

Behaviour:
- Reset value of every output and register:
  - busy = 0, done = 0, overflow = 0.
  - Every seg7_digits field shows "0".
  - seg7_neg_sign is blank.
  - FSM in IDLE.
- Segment encoding is active-low, consistent with the existing seven_segment / seven_segment_negative decoders, which are instantiated per digit and for the sign:
  - blank = 7'h7F
  - dash = 7'h3F (segment g only lit)
- FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE: on start=1, capture val and is_signed; next state LOAD.
- LOAD (1 cycle):
  - neg = is_signed & val[WIDTH-1].
  - mag = neg ? (~val + 1) : val, computed in WIDTH bits, interpreted unsigned.
  - Most-negative value (e.g. 8'h80 -> 128) therefore converts correctly.
  - Clear the BCD accumulator (4*DIGITS + 4 bits; the extra nibble detects overflow).
  - Load the shift counter with WIDTH.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, every nibble ≥5 gets +3.
  - Then {bcd, mag} shifts left by 1 and the counter decrements.
  - Leave SHIFT when the counter reaches 1.
- DONE (1 cycle):
  - Register the outputs, pulse done=1, return to IDLE.
  - overflow = 1 if the top nibble ≠ 0 (any bits shifted past DIGITS*4 are also ORed in).
  - On overflow: all digits show dash, sign unchanged.
- Latency: start accepted at cycle N -> done at cycle N+WIDTH+2. Outputs change only in the done cycle.
- start during LOAD/SHIFT/DONE is ignored (no queuing); val changes while busy have no effect.
- start held high continuously: a new conversion is accepted on the IDLE cycle following DONE, so back-to-back throughput is one conversion per WIDTH+3 cycles.
- rst asserted mid-conversion: next cycle IDLE, all outputs at reset values; no done pulse.
- Zero: never negative; shows "0", sign blank.
- Unsigned mode: the sign is always blank regardless of val[WIDTH-1].

Optional Feature:
- Macro: SEQ_BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Every digit above the most significant non-zero digit shows blank (7'h7F).
  - The ones digit is always shown.
  - The overflow dash display is unaffected.
- Undefined: all DIGITS digits are shown, including leading zeros (default).

Test Plan:
- WIDTH=8, DIGITS=3, is_signed=1, val=8'hF6, pulse start:
  - busy 1 for 10 cycles; done at start+10.
  - Digits "0","1","0"; sign = dash; overflow=0.
- WIDTH=8, DIGITS=3, is_signed=1, val=8'h80 -> digits "1","2","8", sign dash.
- WIDTH=8, DIGITS=3, is_signed=0, val=8'hFF -> "2","5","5", sign blank.
- WIDTH=16, DIGITS=3, is_signed=0, val=1000 -> overflow=1, all digits dash.
- Then val=999 -> overflow=0, "9","9","9".
- WIDTH=8, DIGITS=3, start at cycle 0 with val=42:
  - New start at cycle 4 with val=7 is ignored -> "0","4","2".
  - Start at cycle 3, then rst at cycle 5 -> no done, outputs at reset values, busy=0.
- With SEQ_BCD_LEADING_ZERO_BLANK_EN, WIDTH=8, DIGITS=3, val=5 -> hundreds blank, tens blank, ones "5"; val=0 -> ones "0".
